// File: rtl/simon_datapath.sv
// Simon game datapath: pattern sequence store, play/repeat index,
// status flags and LED source mux for the Simon control FSM.

module simon_datapath_mem #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [3:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [3:0]    o_rdata
);

    logic [3:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

module simon_datapath #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       level,
    input  logic [3:0] pattern,
    input  logic       level_ld,
    input  logic       seq_clr,
    input  logic       seq_wr,
    input  logic       idx_clr,
    input  logic       idx_inc,
    input  logic [1:0] disp_sel,
    output logic [3:0] pattern_leds,
    output logic       legal,
    output logic       match,
    output logic       last,
    output logic       full
);

    localparam logic [AW:0] LEN_FULL = (AW+1)'(DEPTH);

    logic          r_lvl;
    logic [AW:0]   r_len;
    logic [AW-1:0] r_idx;

    logic          w_empty;
    logic          w_full;
    logic          w_last;
    logic          w_wr;
    logic [3:0]    w_rdata;

    assign w_empty = (r_len == '0);
    assign w_full  = (r_len == LEN_FULL);
    assign w_last  = !w_empty && ({1'b0, r_idx} == r_len - 1'b1);

    // A cleared or resetting cycle must not leave a stray entry behind.
    assign w_wr = seq_wr && !w_full && !seq_clr && !reset;

    simon_datapath_mem #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) mem (
        .clk    (clk),
        .i_we   (w_wr),
        .i_waddr(r_len[AW-1:0]),
        .i_wdata(pattern),
        .i_raddr(r_idx),
        .o_rdata(w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lvl <= 1'b0;
            r_len <= '0;
            r_idx <= '0;
        end else begin
            if (level_ld) begin
                r_lvl <= level;
            end
            if (seq_clr) begin
                r_len <= '0;
                r_idx <= '0;
            end else begin
                if (w_wr) begin
                    r_len <= r_len + 1'b1;
                end
                // Wrap decision uses the length before any same-cycle write.
                if (idx_clr) begin
                    r_idx <= '0;
                end else if (idx_inc) begin
                    r_idx <= (w_last || w_empty) ? '0 : r_idx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        pattern_leds = pattern;
        unique case (disp_sel)
            2'b00: pattern_leds = pattern;
            2'b01: pattern_leds = w_rdata;
            2'b10: pattern_leds = 4'b0000;
            2'b11: pattern_leds = 4'b1111;
            default: pattern_leds = pattern;
        endcase
    end

    assign legal = r_lvl || $onehot(pattern);
    assign match = !w_empty && (pattern == w_rdata);
    assign last  = w_last;
    assign full  = w_full;

endmodule

// File: tb/tb_simon_datapath.sv
// Self-checking bench for simon_datapath: directed scenarios plus a
// randomized run checked against a behavioural sequence model.

module tb_simon_datapath;

    logic       clk = 1'b0;
    logic       reset;
    logic       level;
    logic [3:0] pattern;
    logic       level_ld;
    logic       seq_clr;
    logic       seq_wr;
    logic       idx_clr;
    logic       idx_inc;
    logic [1:0] disp_sel;
    logic [3:0] pattern_leds;
    logic       legal;
    logic       match;
    logic       last;
    logic       full;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model of the game sequence
    int         m_len;
    int         m_idx;
    bit         m_lvl;
    logic [3:0] m_mem [64];

    simon_datapath dut (
        .clk         (clk),
        .reset       (reset),
        .level       (level),
        .pattern     (pattern),
        .level_ld    (level_ld),
        .seq_clr     (seq_clr),
        .seq_wr      (seq_wr),
        .idx_clr     (idx_clr),
        .idx_inc     (idx_inc),
        .disp_sel    (disp_sel),
        .pattern_leds(pattern_leds),
        .legal       (legal),
        .match       (match),
        .last        (last),
        .full        (full)
    );

    always #5 clk = ~clk;

    task automatic model_tick();
        int old_len;
        if (reset) begin
            m_lvl = 1'b0;
            m_len = 0;
            m_idx = 0;
            return;
        end
        if (level_ld) m_lvl = level;
        if (seq_clr) begin
            m_len = 0;
            m_idx = 0;
            return;
        end
        old_len = m_len;
        if (seq_wr && m_len < 64) begin
            m_mem[m_len] = pattern;
            m_len = m_len + 1;
        end
        if (idx_clr) m_idx = 0;
        else if (idx_inc) begin
            if (old_len == 0 || m_idx == old_len - 1) m_idx = 0;
            else m_idx = m_idx + 1;
        end
    endtask

    task automatic cycle();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset    = 1'b0;
        level_ld = 1'b0;
        seq_clr  = 1'b0;
        seq_wr   = 1'b0;
        idx_clr  = 1'b0;
        idx_inc  = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        level    = 1'b1;
        pattern  = 4'b0100;
        disp_sel = 2'b00;
        reset    = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        n_cmp++;
        if (last !== 1'b0) begin
            n_err++; $display("FAIL reset_last: got %b want 0", last);
        end
        n_cmp++;
        if (full !== 1'b0) begin
            n_err++; $display("FAIL reset_full: got %b want 0", full);
        end
        n_cmp++;
        if (pattern_leds !== 4'b0100) begin
            n_err++; $display("FAIL reset_leds: got %b want 0100", pattern_leds);
        end
        n_cmp++;
        if (match !== 1'b0) begin
            n_err++; $display("FAIL reset_match: got %b want 0", match);
        end
    endtask

    task automatic test_level();
        level = 1'b0; level_ld = 1'b1;
        cycle();
        level_ld = 1'b0;
        pattern = 4'b0100; #1;
        n_cmp++;
        if (legal !== 1'b1) begin
            n_err++; $display("FAIL legal_easy_0100: got %b want 1", legal);
        end
        pattern = 4'b0110; #1;
        n_cmp++;
        if (legal !== 1'b0) begin
            n_err++; $display("FAIL legal_easy_0110: got %b want 0", legal);
        end
        pattern = 4'b0000; #1;
        n_cmp++;
        if (legal !== 1'b0) begin
            n_err++; $display("FAIL legal_easy_0000: got %b want 0", legal);
        end
        level = 1'b1; level_ld = 1'b1;
        cycle();
        level_ld = 1'b0;
        pattern = 4'b0110; #1;
        n_cmp++;
        if (legal !== 1'b1) begin
            n_err++; $display("FAIL legal_hard_0110: got %b want 1", legal);
        end
        level = 1'b0;
        cycle();
        n_cmp++;
        if (legal !== 1'b1) begin
            n_err++; $display("FAIL legal_no_ld: got %b want 1", legal);
        end
        pattern = 4'b0000; #1;
        n_cmp++;
        if (legal !== 1'b1) begin
            n_err++; $display("FAIL legal_hard_0000: got %b want 1", legal);
        end
    endtask

    task automatic test_playback();
        logic [3:0] seq [3];
        logic [3:0] want [4];
        logic       want_last [4];
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
        want[0] = 4'b0001; want[1] = 4'b0010;
        want[2] = 4'b0100; want[3] = 4'b0001;
        want_last[0] = 0; want_last[1] = 0;
        want_last[2] = 1; want_last[3] = 0;
        seq_clr = 1'b1;
        cycle();
        seq_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seq_wr = 1'b1; pattern = seq[i];
            cycle();
        end
        seq_wr = 1'b0; idx_clr = 1'b1;
        cycle();
        idx_clr = 1'b0; disp_sel = 2'b01; #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                idx_inc = 1'b1;
                cycle();
                idx_inc = 1'b0;
            end
            n_cmp++;
            if (pattern_leds !== want[i]) begin
                n_err++;
                $display("FAIL play_leds[%0d]: got %b want %b", i, pattern_leds, want[i]);
            end
            n_cmp++;
            if (last !== want_last[i]) begin
                n_err++;
                $display("FAIL play_last[%0d]: got %b want %b", i, last, want_last[i]);
            end
        end
    endtask

    task automatic test_match();
        idx_inc = 1'b1;
        cycle();
        idx_inc = 1'b0;
        pattern = 4'b0010; #1;
        n_cmp++;
        if (match !== 1'b1) begin
            n_err++; $display("FAIL match_hit: got %b want 1", match);
        end
        pattern = 4'b0100; #1;
        n_cmp++;
        if (match !== 1'b0) begin
            n_err++; $display("FAIL match_miss: got %b want 0", match);
        end
        seq_clr = 1'b1;
        cycle();
        seq_clr = 1'b0;
        pattern = 4'b0001; #1;
        n_cmp++;
        if (match !== 1'b0) begin
            n_err++; $display("FAIL match_empty: got %b want 0", match);
        end
        n_cmp++;
        if (last !== 1'b0) begin
            n_err++; $display("FAIL last_empty: got %b want 0", last);
        end
    endtask

    task automatic test_fill();
        logic [3:0] exp [64];
        disp_sel = 2'b00;
        for (int i = 0; i < 64; i++) begin
            exp[i] = 4'($urandom);
            seq_wr = 1'b1; pattern = exp[i];
            cycle();
            if (i == 62) begin
                n_cmp++;
                if (full !== 1'b0) begin
                    n_err++; $display("FAIL full_at_63: got %b want 0", full);
                end
            end
        end
        n_cmp++;
        if (full !== 1'b1) begin
            n_err++; $display("FAIL full_at_64: got %b want 1", full);
        end
        pattern = ~exp[0];
        cycle();
        seq_wr = 1'b0;
        n_cmp++;
        if (full !== 1'b1) begin
            n_err++; $display("FAIL full_after_65: got %b want 1", full);
        end
        idx_clr = 1'b1;
        cycle();
        idx_clr = 1'b0; disp_sel = 2'b01; #1;
        n_cmp++;
        if (pattern_leds !== exp[0]) begin
            n_err++; $display("FAIL mem0_kept: got %b want %b", pattern_leds, exp[0]);
        end
        idx_inc = 1'b1;
        for (int i = 0; i < 63; i++) cycle();
        idx_inc = 1'b0;
        n_cmp++;
        if (pattern_leds !== exp[63]) begin
            n_err++; $display("FAIL mem63: got %b want %b", pattern_leds, exp[63]);
        end
        n_cmp++;
        if (last !== 1'b1) begin
            n_err++; $display("FAIL last_at_63: got %b want 1", last);
        end
    endtask

    task automatic test_priority();
        seq_clr = 1'b1; seq_wr = 1'b1; pattern = 4'b1001;
        cycle();
        seq_clr = 1'b0; seq_wr = 1'b0;
        n_cmp++;
        if (full !== 1'b0 || last !== 1'b0) begin
            n_err++;
            $display("FAIL clr_over_wr: full=%b last=%b want 0 0", full, last);
        end
        seq_wr = 1'b1; pattern = 4'b1010;
        cycle();
        seq_wr = 1'b0;
        n_cmp++;
        if (last !== 1'b1) begin
            n_err++; $display("FAIL len1_last: got %b want 1", last);
        end
        reset = 1'b1; seq_wr = 1'b1; idx_inc = 1'b1;
        level = 1'b1; level_ld = 1'b1;
        cycle();
        idle();
        pattern = 4'b0000; disp_sel = 2'b00; #1;
        n_cmp++;
        if (last !== 1'b0 || full !== 1'b0 || match !== 1'b0) begin
            n_err++;
            $display("FAIL reset_strobes: last=%b full=%b match=%b want 0 0 0",
                     last, full, match);
        end
        n_cmp++;
        if (legal !== 1'b0) begin
            n_err++; $display("FAIL reset_lvl: got %b want 0", legal);
        end
        disp_sel = 2'b10; #1;
        n_cmp++;
        if (pattern_leds !== 4'b0000) begin
            n_err++; $display("FAIL leds_sel10: got %b want 0000", pattern_leds);
        end
        disp_sel = 2'b11; #1;
        n_cmp++;
        if (pattern_leds !== 4'b1111) begin
            n_err++; $display("FAIL leds_sel11: got %b want 1111", pattern_leds);
        end
    endtask

    task automatic test_random();
        logic [3:0] e_leds;
        logic       e_legal;
        logic       e_match;
        for (int n = 0; n < 600; n++) begin
            reset    = ($urandom_range(0, 99) == 0);
            seq_clr  = ($urandom_range(0, 39) == 0);
            level_ld = ($urandom_range(0, 9) == 0);
            level    = 1'($urandom);
            seq_wr   = ($urandom_range(0, 2) != 0);
            idx_clr  = ($urandom_range(0, 9) == 0);
            idx_inc  = 1'($urandom);
            pattern  = 4'($urandom);
            disp_sel = 2'($urandom);
            cycle();
            pattern  = 4'($urandom);
            disp_sel = 2'($urandom);
            #1;
            case (disp_sel)
                2'b00:   e_leds = pattern;
                2'b01:   e_leds = m_mem[m_idx];
                2'b10:   e_leds = 4'b0000;
                default: e_leds = 4'b1111;
            endcase
            e_legal = m_lvl || ($countones(pattern) == 1);
            e_match = (m_len != 0) && (pattern == m_mem[m_idx]);
            n_cmp++;
            if (pattern_leds !== e_leds || legal !== e_legal ||
                match !== e_match ||
                last !== (m_len != 0 && m_idx == m_len - 1) ||
                full !== (m_len == 64)) begin
                n_err++;
                $display("FAIL rand[%0d]: leds=%b/%b legal=%b/%b match=%b/%b last=%b full=%b len=%0d idx=%0d",
                         n, pattern_leds, e_leds, legal, e_legal, match, e_match,
                         last, full, m_len, m_idx);
            end
        end
    endtask

    initial begin
        idle();
        level = 1'b0; pattern = 4'b0000; disp_sel = 2'b00;
        test_reset();
        test_level();
        test_playback();
        test_match();
        test_fill();
        test_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
